sd_dat_writer: RTL and testbench
================================

# sd_dat_writer

Single-block SD write data-path transmitter, 1-bit DAT0 mode. Once the controller has accepted CMD24 for a sector, this block drives the 512-byte sector onto DAT0 with CRC16 and checks the card's CRC status token. It then waits out the card's programming busy and reports the result. It shares `sdclk` with the command path and pulls sector bytes from a user buffer through a request/address/byte interface.

## Interface
- `PRECYCLES`, 8: all-ones sdclk cycles driven before the start bit.
- `STATTIMEOUT`, 64: max sdclk rising edges to wait for the status start bit.
- `BUSYTIMEOUT`, 1000000: max sdclk rising edges of DAT0-low busy.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock; asynchronous, active-low.
- `sdclk`  in  1  SD clock from clock divider (≤ clk/2).
- `sddatin`  in  4  card DAT lines; only [0] used.
- `sddatoe`  out  1  DAT output enable.
- `sddatout`  out  4  [3:1] constant 1, [0] = serial bit.
- `wstart`  in  1  begin sector transfer (level-sampled).
- `wbusy`  out  1  high from accept until `wdone`, inclusive.
- `wdone`  out  1  one-clk pulse at completion.
- `werr`  out  2  result: 0 ok, 1 CRC rejected (token 101), 2 write error/other token, 3 timeout.
- `inreq`  out  1  one-clk byte fetch request.
- `inaddr`  out  9  byte index 0..511, valid with `inreq`.
- `inbyte`  in  8  buffer data, valid exactly 1 clk after `inreq`.

## Operation
- Edge detect: register `sdclk` into `sdclkl`. Rising edge = `~sdclkl & sdclk`; falling edge = `sdclkl & ~sdclk`.
- Drive changes happen only on falling edges; sampling happens only on rising edges.
- States: WIDLE, WPRE, WSTART, WDATA, WCRC, WEND, WSTATWAIT, WSTAT, WBUSY, WDONE.
- WIDLE: `sddatoe`=0. `wstart` seen → WPRE, `wbusy`=1, `inreq` for addr 0 in the same clk. `wstart` while `wbusy` is ignored.
- WPRE: oe=1, bit=1 for PRECYCLES falling edges → WSTART.
- WSTART: drive 0 for one falling edge. Clear CRC → WDATA.
- WDATA: 4096 bits, byte 0 first, MSB first. Each bit is fed to the CRC as driven.
  - Byte k+1 is requested (`inreq`, `inaddr`=k+1) on the falling edge that drives bit 0 of byte k.
  - Byte k+1 is latched into the shift register 1 clk later.
  - No request after byte 511.
- WCRC: 16 CRC bits, MSB first. CRC16-CCITT: poly x^16+x^12+x^5+1, init 0x0000, over data bits only.
- WEND: drive 1 for one falling edge. On the next falling edge set oe=0 → WSTATWAIT.
- WSTATWAIT: on each rising edge, DAT0=0 → WSTAT. Otherwise count; count > STATTIMEOUT → WDONE, werr=3.
- WSTAT: sample 3 token bits, then the end bit.
  - Token 010 → WBUSY.
  - Token 101 → WDONE, werr=1.
  - Any other token → WDONE, werr=2.
- WBUSY: on each rising edge, DAT0=1 → WDONE, werr=0. Count > BUSYTIMEOUT → WDONE, werr=3.
- WDONE: `wdone`=1 for one clk → WIDLE. `wbusy` drops the following clk.
- `werr` holds until the next accepted `wstart`.

## Timing
- Reset values: `sddatoe`=0, `sddatout`=4'hf, `wbusy`=0, `wdone`=0, `werr`=0, `inreq`=0, `inaddr`=0, state WIDLE, counters 0, CRC 0.
- Reset mid-transfer releases DAT asynchronously. No partial result is reported.
- Line-time latency from start bit to end bit is 1+4096+16+1 = 4114 sdclk cycles.
- DAT0 is never driven outside WPRE..WEND. Once WEND's bit period ends, oe stays 0 until the next accepted `wstart`.
- Buffer read timing needs ≥2 clk between falling edges, guaranteed by the `sdclk` ≤ clk/2 requirement.
- `inaddr` wraps are not possible: the counter stops at 511.

## Structure
- Shared package `sd_pkg`:
  - write-state enum;
  - `werr` codes (WERR_OK, WERR_CRC, WERR_WRITE, WERR_TIMEOUT);
  - status token constants 3'b010, 3'b101, 3'b110;
  - CRC16 polynomial 16'h1021.
- One sub-module, `sd_crc16`: serial CRC16 with clear, enable and bit inputs and a 16-bit output. It is reusable by the reader for data CRC checking.

## Test plan
- All-0x00 sector, card model token 010 with busy of 10 cycles → DAT0 carries start 0, 4096 zeros, CRC 0x0000, end 1; `wdone` with `werr`=0.
- All-0xFF sector → CRC bits on DAT0 equal 0x7FA1; `werr`=0.
- Byte pattern `inbyte`=addr[7:0] → `inaddr` sequence 0..511, each `inreq` exactly once; serial bits match the buffer in MSB-first order.
- Card replies token 101 → `werr`=1, no WBUSY wait, `sddatoe`=0 throughout the reply.
- No status start bit (DAT0 held 1 for 65 edges) → `werr`=3. Busy held low beyond BUSYTIMEOUT (reduced to 200 in simulation) → `werr`=3.
- `rst_n` asserted at bit 2000 of WDATA → `sddatoe`=0 in the same instant, no `wdone`; a new `wstart` then completes normally with `werr`=0.

Source files
------------

// File: rtl/sd_pkg.sv
// ---------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the SD data-path blocks: the write-path state
// encoding, result codes reported on werr, the CRC status tokens returned
// by the card, and the CRC16-CCITT polynomial with a one-bit update helper
// that both the writer and a future reader use.
// ---------------------------------------------------------------------------
package sd_pkg;

  typedef enum logic [3:0] {
    WIDLE,
    WPRE,
    WSTART,
    WDATA,
    WCRC,
    WEND,
    WSTATWAIT,
    WSTAT,
    WBUSY,
    WDONE
  } wstate_t;

  // Result codes reported on werr
  localparam logic [1:0] WERR_OK      = 2'd0;
  localparam logic [1:0] WERR_CRC     = 2'd1;
  localparam logic [1:0] WERR_WRITE   = 2'd2;
  localparam logic [1:0] WERR_TIMEOUT = 2'd3;

  // CRC status tokens the card returns after a data block
  localparam logic [2:0] TOKEN_ACCEPTED  = 3'b010;
  localparam logic [2:0] TOKEN_CRC_ERR   = 3'b101;
  localparam logic [2:0] TOKEN_WRITE_ERR = 3'b110;

  // x^16 + x^12 + x^5 + 1
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  // One serial step of CRC16-CCITT, MSB-first feedback form.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic        din);
    logic fb;
    fb = crc[15] ^ din;
    crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_crc16.sv
// ---------------------------------------------------------------------------
// sd_crc16
// Serial CRC16-CCITT generator/checker, one bit per enabled clock.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (CRC cleared to 0)
//   clr    in   synchronous clear to 0, has priority over en
//   en     in   advance the CRC by one bit
//   din    in   serial data bit
//   crc    out  current CRC register
// ---------------------------------------------------------------------------
module sd_crc16
  import sd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 16'h0000;
    end else if (clr) begin
      crc <= 16'h0000;
    end else if (en) begin
      crc <= crc16_step(crc, din);
    end
  end

endmodule

// File: rtl/sd_dat_writer.sv
// ---------------------------------------------------------------------------
// sd_dat_writer
// Single-block SD write transmitter in 1-bit (DAT0) mode. After the command
// path has had CMD24 accepted, this block sends PRECYCLES idle ones, a start
// bit, the 512-byte sector (MSB first), the CRC16 and an end bit, then
// releases the line, reads the card's CRC status token and waits out the
// programming busy before reporting the result.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   sdclk    in   SD clock from the divider (at most clk/2)
//   sddatin  in   card DAT lines, only [0] is used
//   sddatoe  out  DAT output enable
//   sddatout out  DAT output, [3:1] held high, [0] serial bit
//   wstart   in   begin a sector transfer (level-sampled while idle)
//   wbusy    out  high from accept up to and including wdone
//   wdone    out  one-clk completion pulse
//   werr     out  result code, held until the next accepted wstart
//   inreq    out  one-clk byte fetch request to the user buffer
//   inaddr   out  byte index 0..511, valid with inreq
//   inbyte   in   buffer data, valid one clk after inreq
// ---------------------------------------------------------------------------
module sd_dat_writer
  import sd_pkg::*;
#(
  parameter int unsigned PRECYCLES   = 8,
  parameter int unsigned STATTIMEOUT = 64,
  parameter int unsigned BUSYTIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sdclk,
  input  logic [3:0] sddatin,
  output logic       sddatoe,
  output logic [3:0] sddatout,
  input  logic       wstart,
  output logic       wbusy,
  output logic       wdone,
  output logic [1:0] werr,
  output logic       inreq,
  output logic [8:0] inaddr,
  input  logic [7:0] inbyte
);

  wstate_t     state, state_nxt;
  logic        sdclkl;
  logic        sd_rise, sd_fall;
  logic [31:0] cnt, cnt_nxt, cnt_inc;
  logic [11:0] bitcnt, bitcnt_nxt;
  logic [7:0]  shreg, shreg_nxt, byte_src;
  logic        ld_q, ld_nxt;
  logic [2:0]  tok, tok_nxt;
  logic        oe_q, oe_nxt;
  logic        dout_q, dout_nxt;
  logic        inreq_q, inreq_nxt;
  logic [8:0]  inaddr_q, inaddr_nxt;
  logic [1:0]  werr_q, werr_nxt;
  logic        crc_clr, crc_en, crc_bit;
  logic [15:0] crc;
  logic        dat0;
  logic        unused_dat;

  assign dat0       = sddatin[0];
  assign unused_dat = ^sddatin[3:1];

  // sdclk comes from the divider in this clock domain; a one-clk-delayed
  // copy gives single-clk pulses marking its edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdclkl <= 1'b0;
    end else begin
      sdclkl <= sdclk;
    end
  end

  assign sd_rise = ~sdclkl & sdclk;
  assign sd_fall = sdclkl & ~sdclk;

  assign cnt_inc = cnt + 32'd1;

  // A fetched byte may arrive on the very clk of the next falling edge, so
  // the shifter takes the bus byte directly when a load is due.
  assign byte_src = ld_q ? inbyte : shreg;

  sd_crc16 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (crc_bit),
    .crc   (crc)
  );

  // State and datapath registers. Reset releases DAT immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WIDLE;
      cnt      <= 32'd0;
      bitcnt   <= 12'd0;
      shreg    <= 8'h00;
      ld_q     <= 1'b0;
      tok      <= 3'b000;
      oe_q     <= 1'b0;
      dout_q   <= 1'b1;
      inreq_q  <= 1'b0;
      inaddr_q <= 9'd0;
      werr_q   <= WERR_OK;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bitcnt   <= bitcnt_nxt;
      shreg    <= shreg_nxt;
      ld_q     <= ld_nxt;
      tok      <= tok_nxt;
      oe_q     <= oe_nxt;
      dout_q   <= dout_nxt;
      inreq_q  <= inreq_nxt;
      inaddr_q <= inaddr_nxt;
      werr_q   <= werr_nxt;
    end
  end

  // Next-state and datapath logic. The line is only changed on sdclk
  // falling edges and the card is only sampled on rising edges.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bitcnt_nxt = bitcnt;
    shreg_nxt  = shreg;
    ld_nxt     = inreq_q;
    tok_nxt    = tok;
    oe_nxt     = oe_q;
    dout_nxt   = dout_q;
    inreq_nxt  = 1'b0;
    inaddr_nxt = inaddr_q;
    werr_nxt   = werr_q;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    crc_bit    = 1'b0;

    if (ld_q) begin
      shreg_nxt = inbyte;
    end

    case (state)
      WIDLE: begin
        oe_nxt   = 1'b0;
        dout_nxt = 1'b1;
        if (wstart) begin
          state_nxt  = WPRE;
          cnt_nxt    = 32'd0;
          bitcnt_nxt = 12'd0;
          werr_nxt   = WERR_OK;
          inreq_nxt  = 1'b1;
          inaddr_nxt = 9'd0;
        end
      end

      WPRE: begin
        if (sd_fall) begin
          oe_nxt   = 1'b1;
          dout_nxt = 1'b1;
          if (cnt == PRECYCLES - 32'd1) begin
            cnt_nxt   = 32'd0;
            state_nxt = WSTART;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end

      WSTART: begin
        if (sd_fall) begin
          dout_nxt   = 1'b0;
          crc_clr    = 1'b1;
          bitcnt_nxt = 12'd0;
          state_nxt  = WDATA;
        end
      end

      WDATA: begin
        if (sd_fall) begin
          dout_nxt   = byte_src[7];
          shreg_nxt  = {byte_src[6:0], 1'b0};
          crc_en     = 1'b1;
          crc_bit    = byte_src[7];
          bitcnt_nxt = bitcnt + 12'd1;
          // The last bit of a byte is on the line, so the shifter is free
          // to receive the following byte.
          if (bitcnt[2:0] == 3'd7 && bitcnt[11:3] != 9'd511) begin
            inreq_nxt  = 1'b1;
            inaddr_nxt = bitcnt[11:3] + 9'd1;
          end
          if (bitcnt == 12'd4095) begin
            cnt_nxt   = 32'd0;
            state_nxt = WCRC;
          end
        end
      end

      WCRC: begin
        if (sd_fall) begin
          dout_nxt = crc[4'd15 - cnt[3:0]];
          if (cnt[3:0] == 4'd15) begin
            cnt_nxt   = 32'd0;
            state_nxt = WEND;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end

      // First falling edge drives the end bit, the second releases DAT.
      WEND: begin
        if (sd_fall) begin
          dout_nxt = 1'b1;
          if (cnt[0] == 1'b0) begin
            cnt_nxt = 32'd1;
          end else begin
            oe_nxt    = 1'b0;
            cnt_nxt   = 32'd0;
            state_nxt = WSTATWAIT;
          end
        end
      end

      WSTATWAIT: begin
        if (sd_rise) begin
          if (!dat0) begin
            cnt_nxt   = 32'd0;
            tok_nxt   = 3'b000;
            state_nxt = WSTAT;
          end else if (cnt_inc > STATTIMEOUT) begin
            werr_nxt  = WERR_TIMEOUT;
            state_nxt = WDONE;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end

      // Three token bits, then the end bit, on which the token is decoded.
      WSTAT: begin
        if (sd_rise) begin
          if (cnt[1:0] != 2'd3) begin
            tok_nxt = {tok[1:0], dat0};
            cnt_nxt = cnt_inc;
          end else begin
            cnt_nxt = 32'd0;
            case (tok)
              TOKEN_ACCEPTED: begin
                state_nxt = WBUSY;
              end
              TOKEN_CRC_ERR: begin
                werr_nxt  = WERR_CRC;
                state_nxt = WDONE;
              end
              TOKEN_WRITE_ERR: begin
                werr_nxt  = WERR_WRITE;
                state_nxt = WDONE;
              end
              default: begin
                werr_nxt  = WERR_WRITE;
                state_nxt = WDONE;
              end
            endcase
          end
        end
      end

      WBUSY: begin
        if (sd_rise) begin
          if (dat0) begin
            werr_nxt  = WERR_OK;
            state_nxt = WDONE;
          end else if (cnt_inc > BUSYTIMEOUT) begin
            werr_nxt  = WERR_TIMEOUT;
            state_nxt = WDONE;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end

      WDONE: begin
        cnt_nxt   = 32'd0;
        state_nxt = WIDLE;
      end

      default: begin
        state_nxt = WIDLE;
      end
    endcase
  end

  assign sddatoe  = oe_q;
  assign sddatout = {3'b111, dout_q};
  assign wbusy    = (state != WIDLE);
  assign wdone    = (state == WDONE);
  assign werr     = werr_q;
  assign inreq    = inreq_q;
  assign inaddr   = inaddr_q;

endmodule

// File: tb/tb_sd_dat_writer.sv
// ---------------------------------------------------------------------------
// tb_sd_dat_writer
// Drives sector transfers through sd_dat_writer with a buffer model and a
// card model, checks the serial frame against a scoreboard of fetched bits
// and a CRC16 model, and checks the reported result codes.
// ---------------------------------------------------------------------------
module tb_sd_dat_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sdclk = 1'b0;
  logic [3:0] sddatin;
  logic       sddatoe;
  logic [3:0] sddatout;
  logic       wstart = 1'b0;
  logic       wbusy;
  logic       wdone;
  logic [1:0] werr;
  logic       inreq;
  logic [8:0] inaddr;
  logic [7:0] inbyte = 8'h00;

  int         checks = 0;
  int         errors = 0;
  string      phase = "reset";

  bit         capQ[$];
  bit         expQ[$];
  int         reqCount = 0;
  int         addrBad = 0;
  logic [8:0] nextAddr = 9'd0;
  int         mode = 0;
  bit         fetchPending = 0;
  logic [7:0] fetchByte = 8'h00;

  int         doneCount = 0;
  logic [1:0] lastErr = 2'd0;
  int         oeClash = 0;
  int         upperBad = 0;
  int         d0 = 0;

  logic       cardOe = 1'b0;
  logic       cardBit = 1'b1;

  always #5 clk = ~clk;
  always #10 sdclk = ~sdclk;

  assign sddatin = {3'b111, cardOe ? cardBit : 1'b1};

  sd_dat_writer #(
    .PRECYCLES   (8),
    .STATTIMEOUT (64),
    .BUSYTIMEOUT (200)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sdclk    (sdclk),
    .sddatin  (sddatin),
    .sddatoe  (sddatoe),
    .sddatout (sddatout),
    .wstart   (wstart),
    .wbusy    (wbusy),
    .wdone    (wdone),
    .werr     (werr),
    .inreq    (inreq),
    .inaddr   (inaddr),
    .inbyte   (inbyte)
  );

  function automatic logic [7:0] patternByte(input int m, input logic [8:0] addr);
    logic [7:0] a;
    a = addr[7:0];
    case (m)
      0:       patternByte = 8'h00;
      1:       patternByte = 8'hFF;
      2:       patternByte = a;
      default: patternByte = (a * 8'd37) ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [15:0] crcModel(input logic [15:0] c, input bit b);
    logic fb;
    fb = c[15] ^ b;
    crcModel = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Buffer model: answers each request one clk later and pushes the
  // byte's bits, MSB first, as the expected serial data.
  initial forever begin
    @(negedge clk);
    if (fetchPending) begin
      inbyte = fetchByte;
      fetchPending = 0;
    end
    if (inreq === 1'b1) begin
      if (inaddr !== nextAddr) addrBad++;
      nextAddr = inaddr + 9'd1;
      reqCount++;
      fetchByte = patternByte(mode, inaddr);
      for (int i = 7; i >= 0; i--) expQ.push_back(fetchByte[i]);
      fetchPending = 1;
    end
  end

  // Line capture: what the card would sample while the host drives DAT.
  initial forever begin
    @(posedge sdclk);
    if (sddatoe === 1'b1) capQ.push_back(sddatout[0]);
  end

  // Completion and bus-ownership monitor.
  initial forever begin
    @(negedge clk);
    if (wdone === 1'b1) begin
      doneCount++;
      lastErr = werr;
    end
    if (cardOe && sddatoe !== 1'b0) oeClash++;
    if (sddatout[3:1] !== 3'b111) upperBad++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s/%s: observed 0x%0h expected 0x%0h", phase, tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int m);
    mode = m;
    capQ.delete();
    expQ.delete();
    reqCount = 0;
    addrBad = 0;
    nextAddr = 9'd0;
    oeClash = 0;
    @(negedge clk);
    wstart = 1'b1;
    @(negedge clk);
    wstart = 1'b0;
    checkOutput("wbusy_on_accept", wbusy, 1);
    checkOutput("werr_cleared_on_accept", werr, 0);
  endtask

  task automatic waitFrameEnd();
    bit sawOe = 0;
    bit ended = 0;
    for (int i = 0; i < 12000 && !ended; i++) begin
      @(negedge clk);
      if (sddatoe === 1'b1) sawOe = 1;
      else if (sawOe) ended = 1;
    end
    checkOutput("frame_end_seen", ended, 1);
  endtask

  task automatic cardReply(input bit sendStart, input logic [2:0] token,
                           input int busyCycles);
    if (sendStart) begin
      @(negedge sdclk);
      cardOe = 1'b1;
      cardBit = 1'b0;
      for (int i = 2; i >= 0; i--) begin
        @(negedge sdclk);
        cardBit = token[i];
      end
      @(negedge sdclk);
      cardBit = 1'b1;
      @(negedge sdclk);
      if (token == 3'b010) begin
        cardBit = 1'b0;
        repeat (busyCycles) @(negedge sdclk);
        cardBit = 1'b1;
        @(negedge sdclk);
      end
      cardOe = 1'b0;
    end
  endtask

  task automatic waitDone(input int startCount, input int limit);
    for (int i = 0; i < limit && doneCount == startCount; i++) @(negedge clk);
    checkOutput("wdone_count", doneCount - startCount, 1);
    @(negedge clk);
    checkOutput("wbusy_dropped", wbusy, 0);
    checkOutput("wdone_one_clk", wdone, 0);
  endtask

  task automatic checkFrame(input bit crcKnown, input logic [15:0] crcConst);
    int         ones = 0;
    int         bad = 0;
    logic [15:0] mcrc = 16'h0000;
    logic [15:0] gotCrc = 16'h0000;
    bit         b;
    checkOutput("frame_bits", capQ.size(), 4122);
    checkOutput("fetched_bits", expQ.size(), 4096);
    checkOutput("req_count", reqCount, 512);
    checkOutput("addr_sequence_errors", addrBad, 0);
    if (capQ.size() == 4122 && expQ.size() == 4096) begin
      for (int i = 0; i < 8; i++) ones += int'(capQ.pop_front());
      checkOutput("precycle_ones", ones, 8);
      checkOutput("start_bit", capQ.pop_front(), 0);
      for (int i = 0; i < 4096; i++) begin
        b = expQ.pop_front();
        mcrc = crcModel(mcrc, b);
        if (capQ.pop_front() != b) bad++;
      end
      checkOutput("data_bit_errors", bad, 0);
      for (int i = 0; i < 16; i++) gotCrc = {gotCrc[14:0], capQ.pop_front()};
      checkOutput("crc_vs_model", gotCrc, mcrc);
      if (crcKnown) checkOutput("crc_vs_const", gotCrc, crcConst);
      checkOutput("end_bit", capQ.pop_front(), 1);
    end
  endtask

  initial begin
    bit reached;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("oe", sddatoe, 0);
    checkOutput("dout", sddatout, 4'hf);
    checkOutput("wbusy", wbusy, 0);
    checkOutput("wdone", wdone, 0);
    checkOutput("werr", werr, 0);
    checkOutput("inreq", inreq, 0);
    checkOutput("inaddr", inaddr, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    phase = "zeros_ok";
    $display("[TB] %s", phase);
    d0 = doneCount;
    applyStimulus(0);
    waitFrameEnd();
    cardReply(1, 3'b010, 10);
    waitDone(d0, 400);
    checkOutput("werr", lastErr, 0);
    checkOutput("oe_during_reply", oeClash, 0);
    checkFrame(1, 16'h0000);

    phase = "ones_ok";
    $display("[TB] %s", phase);
    d0 = doneCount;
    applyStimulus(1);
    repeat (50) @(negedge clk);
    wstart = 1'b1;
    @(negedge clk);
    wstart = 1'b0;
    waitFrameEnd();
    cardReply(1, 3'b010, 3);
    waitDone(d0, 400);
    checkOutput("werr", lastErr, 0);
    checkFrame(1, 16'h7FA1);

    phase = "addr_crc_reject";
    $display("[TB] %s", phase);
    d0 = doneCount;
    applyStimulus(2);
    waitFrameEnd();
    cardReply(1, 3'b101, 0);
    waitDone(d0, 20);
    checkOutput("werr", lastErr, 1);
    checkOutput("oe_during_reply", oeClash, 0);
    checkFrame(0, 16'h0000);

    phase = "no_status";
    $display("[TB] %s", phase);
    repeat (20) @(negedge clk);
    checkOutput("werr_hold", werr, 1);
    d0 = doneCount;
    applyStimulus(3);
    waitFrameEnd();
    cardReply(0, 3'b000, 0);
    waitDone(d0, 400);
    checkOutput("werr", lastErr, 3);
    checkOutput("oe_after_frame", sddatoe, 0);
    checkFrame(0, 16'h0000);

    phase = "busy_timeout";
    $display("[TB] %s", phase);
    d0 = doneCount;
    applyStimulus(0);
    waitFrameEnd();
    cardReply(1, 3'b010, 250);
    waitDone(d0, 1000);
    checkOutput("werr", lastErr, 3);
    checkOutput("oe_during_reply", oeClash, 0);

    phase = "reset_mid_data";
    $display("[TB] %s", phase);
    d0 = doneCount;
    applyStimulus(2);
    reached = 0;
    for (int i = 0; i < 6000 && !reached; i++) begin
      @(posedge clk);
      #1;
      if (capQ.size() >= 9 + 2001) reached = 1;
    end
    checkOutput("bit2000_reached", reached, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("oe_async", sddatoe, 0);
    checkOutput("wbusy_async", wbusy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("no_wdone", doneCount - d0, 0);
    checkOutput("oe_idle", sddatoe, 0);
    checkOutput("werr_after_reset", werr, 0);

    phase = "recovery_ok";
    $display("[TB] %s", phase);
    d0 = doneCount;
    applyStimulus(2);
    waitFrameEnd();
    cardReply(1, 3'b010, 5);
    waitDone(d0, 400);
    checkOutput("werr", lastErr, 0);
    checkOutput("oe_during_reply", oeClash, 0);
    checkFrame(0, 16'h0000);
    checkOutput("upper_dat_bits", upperBad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
